// File: rtl/i2c_master_arbiter.sv
// Arbitrates NREQ clients onto one i2c_master: latches the winner's command, pulses start,
// then waits for read data (with timeout) or a fixed write time. Define I2C_ARB_RR_EN for round-robin.
module i2c_master_arbiter #(
    parameter int NREQ           = 4,
    parameter int WR_CYCLES      = 4000,
    parameter int TIMEOUT_CYCLES = 8000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NREQ-1:0]    req_i,
    input  logic [NREQ*24-1:0] req_data_i,
    output logic [NREQ-1:0]    gnt_o,
    output logic [NREQ-1:0]    ack_o,
    output logic               err_o,
    output logic [7:0]         rdata_o,
    output logic               busy_o,
    output logic               ms_start_o,
    output logic [23:0]        ms_data_o,
    input  logic [7:0]         ms_rdata_i,
    input  logic               ms_rxdone_i
);

    localparam int MAXC = (WR_CYCLES > TIMEOUT_CYCLES) ? WR_CYCLES : TIMEOUT_CYCLES;
    localparam int CW   = $clog2(MAXC);
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_r, next_state_s;
    logic [NREQ-1:0]     gnt_r, gnt_s;
    logic [NREQ-1:0]     ack_r, ack_s;
    logic                err_r, err_s;
    logic [7:0]          rdata_r, rdata_s;
    logic                busy_r, busy_s;
    logic                ms_start_r, ms_start_s;
    logic [23:0]         ms_data_r, ms_data_s;
    logic [CW-1:0]       cnt_r, cnt_s;
    logic [IW-1:0]       win_r, win_s, pick_s;
    logic [IW-1:0]       ptr_s;

    // Lowest requesting index at or after 'start', wrapping; start = 0 gives fixed priority.
    function automatic logic [IW-1:0] pick_from(input logic [NREQ-1:0] req, input logic [IW-1:0] start);
        logic [IW-1:0] pick;
        logic          found;
        int            j;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(start) + k) % NREQ;
            if (!found && req[j]) begin
                pick  = IW'(j);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

`ifdef I2C_ARB_RR_EN
    logic [IW-1:0] ptr_r;

    // Round-robin pointer follows the last served requester.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_r <= '0;
        end else if (state_r == ST_DONE) begin
            ptr_r <= win_r;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Search begins one past the last winner.
    always_comb begin
        ptr_s = IW'((int'(ptr_r) + 1) % NREQ);
    end
`else
    // Fixed priority always searches from index 0.
    always_comb begin
        ptr_s = '0;
    end
`endif

    // Winner selection from the current request vector.
    always_comb begin
        pick_s = pick_from(req_i, ptr_s);
    end

    // State and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r    <= ST_IDLE;
            gnt_r      <= '0;
            ack_r      <= '0;
            err_r      <= 1'b0;
            rdata_r    <= 8'h00;
            busy_r     <= 1'b0;
            ms_start_r <= 1'b0;
            ms_data_r  <= 24'h000000;
            cnt_r      <= '0;
            win_r      <= '0;
        end else begin
            state_r    <= next_state_s;
            gnt_r      <= gnt_s;
            ack_r      <= ack_s;
            err_r      <= err_s;
            rdata_r    <= rdata_s;
            busy_r     <= busy_s;
            ms_start_r <= ms_start_s;
            ms_data_r  <= ms_data_s;
            cnt_r      <= cnt_s;
            win_r      <= win_s;
        end
    end

    // Next-state logic; rxdone only matters in WAIT on a read and beats the timeout.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (|req_i) next_state_s = ST_START;
                else        next_state_s = ST_IDLE;
            end
            ST_START: next_state_s = ST_WAIT;
            ST_WAIT: begin
                if (ms_data_r[16]) begin
                    if (ms_rxdone_i || (cnt_r == '0)) next_state_s = ST_DONE;
                    else                              next_state_s = ST_WAIT;
                end else begin
                    if (cnt_r == '0) next_state_s = ST_DONE;
                    else             next_state_s = ST_WAIT;
                end
            end
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, datapath and counter.
    always_comb begin
        gnt_s      = gnt_r;
        ack_s      = '0;
        err_s      = 1'b0;
        rdata_s    = rdata_r;
        ms_start_s = 1'b0;
        ms_data_s  = ms_data_r;
        cnt_s      = cnt_r;
        win_s      = win_r;
        busy_s     = (next_state_s != ST_IDLE);
        case (state_r)
            ST_IDLE: begin
                if (|req_i) begin
                    win_s      = pick_s;
                    gnt_s      = {{(NREQ-1){1'b0}}, 1'b1} << pick_s;
                    ms_data_s  = req_data_i[int'(pick_s)*24 +: 24];
                    ms_start_s = 1'b1;
                end else begin
                    gnt_s = '0;
                end
            end
            ST_START: begin
                if (ms_data_r[16]) cnt_s = CW'(TIMEOUT_CYCLES - 1);
                else               cnt_s = CW'(WR_CYCLES - 1);
            end
            ST_WAIT: begin
                if (ms_data_r[16] && ms_rxdone_i) begin
                    rdata_s = ms_rdata_i;
                    ack_s   = gnt_r;
                end else if (cnt_r == '0) begin
                    ack_s = gnt_r;
                    err_s = ms_data_r[16];
                end else begin
                    cnt_s = cnt_r - CW'(1);
                end
            end
            ST_DONE: begin
                gnt_s = '0;
            end
            default: begin
                gnt_s = '0;
            end
        endcase
    end

    assign gnt_o      = gnt_r;
    assign ack_o      = ack_r;
    assign err_o      = err_r;
    assign rdata_o    = rdata_r;
    assign busy_o     = busy_r;
    assign ms_start_o = ms_start_r;
    assign ms_data_o  = ms_data_r;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed bench for i2c_master_arbiter with shortened write/timeout windows.
module tb_i2c_master_arbiter;

    localparam int NREQ = 4;
    localparam int WR   = 20;
    localparam int TO   = 40;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       req;
    logic [95:0]      req_data;
    logic [3:0]       gnt, ack;
    logic             err, busy, ms_start, ms_rxdone;
    logic [7:0]       rdata, ms_rdata;
    logic [23:0]      ms_data;
    int               n_cmp = 0;
    int               n_mis = 0;
    int               cnt;

    i2c_master_arbiter #(.NREQ(NREQ), .WR_CYCLES(WR), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .req_data_i(req_data),
        .gnt_o(gnt), .ack_o(ack), .err_o(err), .rdata_o(rdata), .busy_o(busy),
        .ms_start_o(ms_start), .ms_data_o(ms_data), .ms_rdata_i(ms_rdata), .ms_rxdone_i(ms_rxdone)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int bound);
        cnt = 0;
        while (ack === 4'b0000 && cnt < bound) begin
            tick();
            cnt++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; req = 4'b0000; req_data = '0; ms_rdata = 8'h00; ms_rxdone = 1'b0;
        tick(); tick();
        n_cmp++; if (gnt !== 4'b0000) begin n_mis++; $display("FAIL reset_gnt: got %h want %h", gnt, 4'h0); end
        n_cmp++; if (ack !== 4'b0000 || err !== 1'b0) begin n_mis++; $display("FAIL reset_ack_err: got %h/%b want 0/0", ack, err); end
        n_cmp++; if (busy !== 1'b0 || ms_start !== 1'b0) begin n_mis++; $display("FAIL reset_busy_start: got %b/%b want 0/0", busy, ms_start); end
        n_cmp++; if (ms_data !== 24'h000000 || rdata !== 8'h00) begin n_mis++; $display("FAIL reset_data: got %h/%h want 0/0", ms_data, rdata); end
        rst = 1'b0;
    endtask

    task automatic test_write;
        req_data[23:0] = 24'hA0105A; req = 4'b0001;
        tick();
        n_cmp++; if (ms_start !== 1'b1 || ms_data !== 24'hA0105A) begin n_mis++; $display("FAIL wr_start: got %b/%h want 1/a0105a", ms_start, ms_data); end
        n_cmp++; if (gnt !== 4'b0001 || busy !== 1'b1) begin n_mis++; $display("FAIL wr_gnt: got %h/%b want 1/1", gnt, busy); end
        req = 4'b0000;
        cnt = 0;
        while (ack === 4'b0000 && cnt < 100) begin
            tick();
            cnt++;
            if (cnt == 1) begin
                n_cmp++; if (ms_start !== 1'b0) begin n_mis++; $display("FAIL wr_start_pulse: got %b want 0", ms_start); end
            end
            // rxdone during a write must be ignored
            if (cnt == 5) begin ms_rxdone = 1'b1; ms_rdata = 8'hFF; end
            else begin ms_rxdone = 1'b0; ms_rdata = 8'h00; end
        end
        n_cmp++; if (cnt !== WR + 1) begin n_mis++; $display("FAIL wr_latency: got %0d want %0d", cnt, WR + 1); end
        n_cmp++; if (ack !== 4'b0001 || err !== 1'b0) begin n_mis++; $display("FAIL wr_ack: got %h/%b want 1/0", ack, err); end
        n_cmp++; if (ms_data !== 24'hA0105A || rdata !== 8'h00) begin n_mis++; $display("FAIL wr_hold: got %h/%h want a0105a/00", ms_data, rdata); end
        tick();
        n_cmp++; if (ack !== 4'b0000 || gnt !== 4'b0000 || busy !== 1'b0) begin n_mis++; $display("FAIL wr_end: got %h/%h/%b want 0/0/0", ack, gnt, busy); end
    endtask

    task automatic test_read;
        req_data[47:24] = 24'hA12200; req = 4'b0010;
        tick();
        n_cmp++; if (gnt !== 4'b0010 || ms_start !== 1'b1 || ms_data !== 24'hA12200) begin n_mis++; $display("FAIL rd_start: got %h/%b/%h want 2/1/a12200", gnt, ms_start, ms_data); end
        req = 4'b0000;
        repeat (10) tick();
        n_cmp++; if (ack !== 4'b0000) begin n_mis++; $display("FAIL rd_early: got %h want 0", ack); end
        ms_rxdone = 1'b1; ms_rdata = 8'h3C;
        tick();
        ms_rxdone = 1'b0; ms_rdata = 8'h00;
        n_cmp++; if (ack !== 4'b0010 || err !== 1'b0) begin n_mis++; $display("FAIL rd_ack: got %h/%b want 2/0", ack, err); end
        n_cmp++; if (rdata !== 8'h3C) begin n_mis++; $display("FAIL rd_data: got %h want 3c", rdata); end
        tick();
        n_cmp++; if (ack !== 4'b0000 || busy !== 1'b0) begin n_mis++; $display("FAIL rd_end: got %h/%b want 0/0", ack, busy); end
    endtask

    task automatic test_timeout;
        req_data[71:48] = 24'hA10100; req = 4'b0100;
        tick();
        n_cmp++; if (gnt !== 4'b0100) begin n_mis++; $display("FAIL to_gnt: got %h want 4", gnt); end
        req = 4'b0000;
        wait_ack(200);
        n_cmp++; if (cnt !== TO + 1) begin n_mis++; $display("FAIL to_latency: got %0d want %0d", cnt, TO + 1); end
        n_cmp++; if (ack !== 4'b0100 || err !== 1'b1) begin n_mis++; $display("FAIL to_ack_err: got %h/%b want 4/1", ack, err); end
        n_cmp++; if (rdata !== 8'h3C) begin n_mis++; $display("FAIL to_rdata: got %h want 3c", rdata); end
        tick();
        n_cmp++; if (err !== 1'b0 || ack !== 4'b0000) begin n_mis++; $display("FAIL to_end: got %b/%h want 0/0", err, ack); end
    endtask

    task automatic test_coincident;
        req_data[95:72] = 24'hA13300; req = 4'b1000;
        tick();
        req = 4'b0000;
        repeat (TO) tick();
        n_cmp++; if (ack !== 4'b0000) begin n_mis++; $display("FAIL co_early: got %h want 0", ack); end
        ms_rxdone = 1'b1; ms_rdata = 8'h77;
        tick();
        ms_rxdone = 1'b0; ms_rdata = 8'h00;
        n_cmp++; if (ack !== 4'b1000 || err !== 1'b0) begin n_mis++; $display("FAIL co_ack: got %h/%b want 8/0", ack, err); end
        n_cmp++; if (rdata !== 8'h77) begin n_mis++; $display("FAIL co_rdata: got %h want 77", rdata); end
        tick();
    endtask

    task automatic test_arbitration;
        logic [23:0] tab [4];
        int          order [3];
        logic [3:0]  exp_g;
        int          e;
        tab[0] = 24'hA00000; tab[1] = 24'hA00011; tab[2] = 24'hA00022; tab[3] = 24'hA00033;
`ifdef I2C_ARB_RR_EN
        order[0] = 1; order[1] = 3; order[2] = 0;
`else
        order[0] = 0; order[1] = 1; order[2] = 3;
`endif
        rst = 1'b1; tick(); rst = 1'b0;
        for (int k = 0; k < 4; k++) req_data[24*k +: 24] = tab[k];
        req = 4'b1011;
        for (int i = 0; i < 3; i++) begin
            e = order[i];
            exp_g = 4'b0001 << e;
            tick();
            n_cmp++; if (gnt !== exp_g || ms_data !== tab[e]) begin n_mis++; $display("FAIL arb_gnt%0d: got %h/%h want %h/%h", i, gnt, ms_data, exp_g, tab[e]); end
            wait_ack(100);
            n_cmp++; if (ack !== exp_g || cnt !== WR + 1) begin n_mis++; $display("FAIL arb_ack%0d: got %h/%0d want %h/%0d", i, ack, cnt, exp_g, WR + 1); end
            req[e] = 1'b0;
            tick();
            n_cmp++; if (busy !== 1'b0 || gnt !== 4'b0000) begin n_mis++; $display("FAIL arb_idle%0d: got %b/%h want 0/0", i, busy, gnt); end
        end
        req = 4'b0000;
    endtask

    task automatic test_reset_mid;
        req_data[23:0] = 24'hA00044; req = 4'b0001;
        tick();
        req = 4'b0000;
        repeat (5) tick();
        n_cmp++; if (busy !== 1'b1) begin n_mis++; $display("FAIL rm_busy: got %b want 1", busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (gnt !== 4'b0000 || busy !== 1'b0 || ack !== 4'b0000) begin n_mis++; $display("FAIL rm_reset: got %h/%b/%h want 0/0/0", gnt, busy, ack); end
        n_cmp++; if (ms_data !== 24'h000000 || ms_start !== 1'b0) begin n_mis++; $display("FAIL rm_ms: got %h/%b want 0/0", ms_data, ms_start); end
        tick();
        n_cmp++; if (ack !== 4'b0000 || busy !== 1'b0) begin n_mis++; $display("FAIL rm_noack: got %h/%b want 0/0", ack, busy); end
        req_data[71:48] = 24'hA15500; req = 4'b0100;
        tick();
        n_cmp++; if (gnt !== 4'b0100 || ms_start !== 1'b1 || ms_data !== 24'hA15500) begin n_mis++; $display("FAIL rm_fresh: got %h/%b/%h want 4/1/a15500", gnt, ms_start, ms_data); end
        req = 4'b0000;
        tick();
        ms_rxdone = 1'b1; ms_rdata = 8'h5A;
        tick();
        ms_rxdone = 1'b0; ms_rdata = 8'h00;
        n_cmp++; if (ack !== 4'b0100 || err !== 1'b0 || rdata !== 8'h5A) begin n_mis++; $display("FAIL rm_ack: got %h/%b/%h want 4/0/5a", ack, err, rdata); end
        tick();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_coincident();
        test_arbitration();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
